// File: rtl/step_sequencer_if.sv
// Fetch/bus inputs and control-strobe outputs of the step sequencer.
// The slave modport is the sequencer; the master side drives start and bus.
interface step_sequencer_if #(
    parameter int CNTW = 8
);
    logic            start;
    logic [9:0]      bus;
    logic            Ext;
    logic            IRin;
    logic [1:0]      Rin;
    logic            ENW;
    logic [1:0]      Rout;
    logic            ENR;
    logic            Ain;
    logic            Gin;
    logic            Gout;
    logic [3:0]      FN;
    logic [1:0]      T;
    logic            done;
    logic            err;
    logic [CNTW-1:0] icount;

    modport master (
        output start, bus,
        input  Ext, IRin, Rin, ENW, Rout, ENR, Ain, Gin, Gout, FN, T, done, err, icount
    );

    modport slave (
        input  start, bus,
        output Ext, IRin, Rin, ENW, Rout, ENR, Ain, Gin, Gout, FN, T, done, err, icount
    );
endinterface

// File: rtl/step_sequencer.sv
// Multi-cycle instruction sequencer: fetches from the shared bus in T0 and
// steps LOAD/MOV/ALU instructions through T1-T3, trapping illegal opcodes.
//
// state  | meaning
// S_T0   | fetch; latch IR from bus when start=1
// S_T1   | first execute step (LOAD/MOV finish here)
// S_T2   | ALU operand / function step
// S_T3   | ALU writeback, done
// S_TRAP | illegal opcode, held until CLRn
module step_sequencer #(
    parameter int CNTW = 8
) (
    input  logic             CLKb,
    input  logic             CLRn,
    step_sequencer_if.slave  sif
);

    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_TRAP = 3'd4
    } state_t;

    state_t          state_q, state_d;
    // IR[5:4] carry no meaning, so only Rx, Ry and the opcode are kept.
    logic [7:0]      ir_q, ir_d;
    logic [CNTW-1:0] icount_q, icount_d;

    logic [1:0] rx, ry;
    logic [3:0] op;
    logic       op_bin, op_un;

    logic       ext, irin, enw, enr, ain, gin, gout, done, err;
    logic [1:0] rin, rout;
    logic [3:0] fn;

    assign rx     = ir_q[7:6];
    assign ry     = ir_q[5:4];
    assign op     = ir_q[3:0];
    assign op_bin = (op >= 4'd2) && (op <= 4'd6);
    assign op_un  = (op == 4'd7) || (op == 4'd8);

    always_ff @(posedge CLKb or negedge CLRn) begin
        if (!CLRn) begin
            state_q  <= S_T0;
            ir_q     <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        icount_d = icount_q;
        ext      = 1'b0;
        irin     = 1'b0;
        rin      = 2'd0;
        enw      = 1'b0;
        rout     = 2'd0;
        enr      = 1'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        gout     = 1'b0;
        fn       = 4'd0;
        done     = 1'b0;
        err      = 1'b0;

        case (state_q)
            S_T0: begin
                if (sif.start) begin
                    ext     = 1'b1;
                    irin    = 1'b1;
                    ir_d    = {sif.bus[9:6], sif.bus[3:0]};
                    state_d = S_T1;
                end
            end
            S_T1: begin
                state_d = S_T2;
                if (op == 4'd0) begin
                    ext  = 1'b1;
                    rin  = rx;
                    enw  = 1'b1;
                    done = 1'b1;
                end else if (op == 4'd1) begin
                    rout = ry;
                    enr  = 1'b1;
                    rin  = rx;
                    enw  = 1'b1;
                    done = 1'b1;
                end else if (op_bin || op_un) begin
                    rout = op_bin ? rx : ry;
                    enr  = 1'b1;
                    ain  = 1'b1;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_T2: begin
                state_d = S_T3;
                gin     = 1'b1;
                fn      = op;
                if (op_bin) begin
                    rout = ry;
                    enr  = 1'b1;
                end
            end
            S_T3: begin
                gout = 1'b1;
                rin  = rx;
                enw  = 1'b1;
                done = 1'b1;
            end
            S_TRAP: begin
                err = 1'b1;
            end
            default: begin
                state_d = S_T0;
            end
        endcase

        if (done) begin
            state_d  = S_T0;
            icount_d = icount_q + CNTW'(1);
        end
    end

    assign sif.Ext    = ext;
    assign sif.IRin   = irin;
    assign sif.Rin    = rin;
    assign sif.ENW    = enw;
    assign sif.Rout   = rout;
    assign sif.ENR    = enr;
    assign sif.Ain    = ain;
    assign sif.Gin    = gin;
    assign sif.Gout   = gout;
    assign sif.FN     = fn;
    assign sif.T      = (state_q == S_TRAP) ? 2'd3 : state_q[1:0];
    assign sif.done   = done;
    assign sif.err    = err;
    assign sif.icount = icount_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: per-instruction micro-step lists as the reference,
// directed scenarios pinned with literals, then a long randomized run.
module tb_step_sequencer;
    localparam int CNTW = 2;

    logic CLKb = 1'b0;
    logic CLRn = 1'b0;

    step_sequencer_if #(.CNTW(CNTW)) sif();
    step_sequencer #(.CNTW(CNTW)) dut (.CLKb(CLKb), .CLRn(CLRn), .sif(sif));

    always #5 CLKb = ~CLKb;

    typedef struct packed {
        logic       ext;
        logic       irin;
        logic [1:0] rin;
        logic       enw;
        logic [1:0] rout;
        logic       enr;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] fn;
        logic [1:0] t;
        logic       done;
        logic       err;
    } outs_t;

    // Remaining execute steps of the instruction in flight (empty = in T0).
    outs_t steps[$];
    bit    trap_after[$];
    bit    m_trap;
    int    m_icount;
    int    checks;
    int    errors;

    task automatic push(input outs_t s, input bit tr);
        steps.push_back(s);
        trap_after.push_back(tr);
    endtask

    task automatic model_fetch(input logic [9:0] w);
        logic [1:0] rx;
        logic [1:0] ry;
        logic [3:0] op;
        outs_t s;
        rx = w[9:8];
        ry = w[7:6];
        op = w[3:0];
        if (op == 4'd0) begin
            s = '0; s.ext = 1; s.rin = rx; s.enw = 1; s.done = 1; s.t = 2'd1;
            push(s, 0);
        end else if (op == 4'd1) begin
            s = '0; s.rout = ry; s.enr = 1; s.rin = rx; s.enw = 1; s.done = 1; s.t = 2'd1;
            push(s, 0);
        end else if (op <= 4'd8) begin
            s = '0; s.rout = (op <= 4'd6) ? rx : ry; s.enr = 1; s.ain = 1; s.t = 2'd1;
            push(s, 0);
            s = '0; s.gin = 1; s.fn = op; s.t = 2'd2;
            if (op <= 4'd6) begin s.rout = ry; s.enr = 1; end
            push(s, 0);
            s = '0; s.gout = 1; s.rin = rx; s.enw = 1; s.done = 1; s.t = 2'd3;
            push(s, 0);
        end else begin
            s = '0; s.t = 2'd1;
            push(s, 1);
        end
    endtask

    task automatic model_reset();
        steps.delete();
        trap_after.delete();
        m_trap   = 0;
        m_icount = 0;
    endtask

    task automatic model_advance();
        outs_t s;
        bit    tr;
        if (m_trap) return;
        if (steps.size() == 0) begin
            if (sif.start) model_fetch(sif.bus);
        end else begin
            s  = steps.pop_front();
            tr = trap_after.pop_front();
            if (s.done) m_icount++;
            if (tr) m_trap = 1;
        end
    endtask

    function automatic outs_t model_expect();
        outs_t e;
        e = '0;
        if (m_trap) begin
            e.err = 1;
            e.t   = 2'd3;
        end else if (steps.size() == 0) begin
            if (sif.start) begin
                e.ext  = 1;
                e.irin = 1;
            end
        end else begin
            e = steps[0];
        end
        return e;
    endfunction

    function automatic outs_t dut_outs();
        return {sif.Ext, sif.IRin, sif.Rin, sif.ENW, sif.Rout, sif.ENR, sif.Ain,
                sif.Gin, sif.Gout, sif.FN, sif.T, sif.done, sif.err};
    endfunction

    task automatic check_lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_now();
        outs_t a;
        outs_t e;
        logic [CNTW-1:0] ei;
        a  = dut_outs();
        e  = model_expect();
        ei = CNTW'(m_icount);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL outs: got 0x%05h expected 0x%05h at %0t", a, e, $time);
        end
        checks++;
        if (sif.icount !== ei) begin
            errors++;
            $display("FAIL icount: got %0d expected %0d at %0t", sif.icount, ei, $time);
        end
        checks++;
        if ((int'(sif.Ext) + int'(sif.ENR) + int'(sif.Gout)) > 1 || (sif.ENW && sif.IRin)) begin
            errors++;
            $display("FAIL exclusivity: Ext=%0b ENR=%0b Gout=%0b ENW=%0b IRin=%0b expected at most one driver, no ENW with IRin at %0t",
                     sif.Ext, sif.ENR, sif.Gout, sif.ENW, sif.IRin, $time);
        end
    endtask

    task automatic setup(input logic st, input logic [9:0] b, input logic rn);
        sif.start = st;
        sif.bus   = b;
        CLRn      = rn;
        if (!rn) model_reset();
    endtask

    task automatic neg_cmp();
        @(negedge CLKb);
        compare_now();
    endtask

    task automatic clk_edge();
        @(posedge CLKb);
        if (CLRn) model_advance();
        #1;
    endtask

    task automatic cyc(input logic st, input logic [9:0] b, input logic rn);
        setup(st, b, rn);
        neg_cmp();
        clk_edge();
    endtask

    function automatic logic [9:0] rand_word();
        logic [9:0] w;
        w = 10'($urandom);
        if ($urandom_range(0, 29) == 0) w[3:0] = 4'($urandom_range(9, 15));
        else                            w[3:0] = 4'($urandom_range(0, 8));
        return w;
    endfunction

    initial begin
        int         tseq;
        logic [6:0] dv;
        checks = 0;
        errors = 0;
        model_reset();
        sif.start = 0;
        sif.bus   = '0;
        @(posedge CLKb);
        #1;

        // reset / idle
        setup(0, 10'h3FF, 0); neg_cmp();
        check_lit("rst_idle_outs", int'(dut_outs()), 0);
        check_lit("rst_icount", int'(sif.icount), 0);
        clk_edge();
        setup(1, 10'h3FF, 0); neg_cmp();
        check_lit("rst_start_outs", int'(dut_outs()), 32'h60000);
        clk_edge();
        for (int i = 0; i < 3; i++) cyc(0, rand_word(), 1);
        setup(0, 10'h000, 1); neg_cmp();
        check_lit("idle_T", int'(sif.T), 0);
        clk_edge();

        // LOAD R2
        cyc(1, 10'b10_00_00_0000, 1);
        setup(0, 10'h155, 1); neg_cmp();
        check_lit("load_t1", int'({sif.Ext, sif.Rin, sif.ENW, sif.done}), 5'b1_10_1_1);
        clk_edge();
        setup(0, 10'h2AA, 1); neg_cmp();
        check_lit("load_icount", int'(sif.icount), 1);
        check_lit("load_back_T0", int'(sif.T), 0);
        clk_edge();

        // ADD R1,R3
        setup(1, 10'b01_11_00_0010, 1); neg_cmp();
        tseq = int'(sif.T);
        clk_edge();
        setup(0, rand_word(), 1); neg_cmp();
        check_lit("add_t1", int'({sif.Rout, sif.ENR, sif.Ain}), 4'b01_1_1);
        tseq = tseq * 4 + int'(sif.T);
        clk_edge();
        setup(0, rand_word(), 1); neg_cmp();
        check_lit("add_t2", int'({sif.Rout, sif.ENR, sif.Gin, sif.FN}), 8'b11_1_1_0010);
        tseq = tseq * 4 + int'(sif.T);
        clk_edge();
        setup(0, rand_word(), 1); neg_cmp();
        check_lit("add_t3", int'({sif.Gout, sif.Rin, sif.ENW, sif.done}), 5'b1_01_1_1);
        tseq = tseq * 4 + int'(sif.T);
        clk_edge();
        setup(0, rand_word(), 1); neg_cmp();
        tseq = tseq * 4 + int'(sif.T);
        check_lit("add_tseq", tseq, 108);
        check_lit("add_icount", int'(sif.icount), 2);
        clk_edge();

        // back-to-back MOV R0<-R1, NOT R3<-R2
        dv = '0;
        for (int i = 0; i < 7; i++) begin
            setup(i < 6, (i == 0) ? 10'h041 : (i == 2) ? 10'h387 : rand_word(), 1);
            neg_cmp();
            dv[i] = sif.done;
            clk_edge();
        end
        check_lit("b2b_done_pattern", int'(dv), 7'b0100010);
        setup(0, 10'h000, 1); neg_cmp();
        check_lit("b2b_icount_wrap", int'(sif.icount), 0);
        clk_edge();

        // illegal opcode 1010
        cyc(1, 10'b00_00_00_1010, 1);
        setup(1, rand_word(), 1); neg_cmp();
        check_lit("ill_t1", int'({sif.T, sif.err}), 3'b01_0);
        clk_edge();
        for (int i = 0; i < 5; i++) begin
            setup(1, rand_word(), 1); neg_cmp();
            check_lit("trap_outs", int'(dut_outs()), 32'h0000D);
            clk_edge();
        end
        setup(0, rand_word(), 0); neg_cmp();
        check_lit("trap_clr", int'({sif.err, sif.T, sif.icount}), 0);
        clk_edge();
        cyc(0, rand_word(), 1);

        // reset during T2 of SUB
        cyc(1, 10'b00_00_00_0000, 1);
        cyc(0, rand_word(), 1);
        cyc(1, 10'b10_01_00_0011, 1);
        cyc(0, rand_word(), 1);
        setup(0, rand_word(), 1); neg_cmp();
        check_lit("sub_at_t2", int'({sif.T, sif.icount}), 4'b10_01);
        setup(0, sif.bus, 0);
        #1;
        compare_now();
        check_lit("midop_clr", int'({dut_outs(), sif.icount}), 0);
        clk_edge();
        cyc(0, rand_word(), 0);
        cyc(0, rand_word(), 1);
        cyc(0, rand_word(), 1);

        // icount wrap with CNTW=2
        for (int k = 1; k <= 4; k++) begin
            cyc(1, {2'($urandom), 4'($urandom), 4'd0}, 1);
            cyc(0, rand_word(), 1);
            setup(0, rand_word(), 1); neg_cmp();
            check_lit("wrap_icount", int'(sif.icount), k % 4);
            clk_edge();
        end

        // randomized run
        for (int n = 0; n < 3000; n++) begin
            logic rn;
            rn = 1'b1;
            if ($urandom_range(0, 99) == 0) rn = 1'b0;
            if (m_trap && $urandom_range(0, 3) == 0) rn = 1'b0;
            cyc($urandom_range(0, 9) < 7, rand_word(), rn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
